// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset constants,
// FSM state encodings and the fetch-entry record carried through IF/ID.
package if_fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [PC_W-1:0]   RESET_PC = 32'hBFC0_0000;
    localparam logic [INST_W-1:0] NOP_CODE = 32'h0000_0000;  // sll $0,$0,0

    // RUN: normal fetching. DROP: one response is still owed for an address
    // issued before a redirect and must be swallowed.
    typedef enum logic {
        IF_RUN  = 1'b0,
        IF_DROP = 1'b1
    } if_state_t;

    // One fetched instruction as it travels to ID.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic              adel;
    } fetch_entry_t;

    function automatic logic pc_aligned(input logic [PC_W-1:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched {inst, pc, adel} while ID stalls.
// Clear beats load; a load in the same cycle as a drain refills the slot.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         drain,
    input  fetch_entry_t d,
    output logic         valid,
    output fetch_entry_t q
);

    // Occupancy flag: clear, then load, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Payload capture on load.
    // NOTE: the payload is deliberately not reset; every consumer qualifies it with valid.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage with IF/ID latch: owns the PC, drives the req/ack
// instruction bus, absorbs ID stalls through a one-entry skid buffer and
// handles redirects, including swallowing a response already in flight.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC_P = RESET_PC,
    parameter logic [INST_W-1:0] NOP_CODE_P = NOP_CODE
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ibus_req,
    output logic [PC_W-1:0]   ibus_addr,
    input  logic              ibus_ack,
    input  logic [INST_W-1:0] ibus_rdata,
    input  logic              id_stall,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [INST_W-1:0] id_inst_code,
    output logic [PC_W-1:0]   id_pc,
    output logic              id_valid,
    output logic              id_exc_adel
);

    if_state_t    state, state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] drop_addr;   // address still owed a response while in DROP
    logic         started;        // keeps req low until the first edge after reset
    logic         adel_done;      // misaligned pc already reported to ID

    logic         aligned;
    logic         fetch_ok;
    logic         accept;
    logic         adel_issue;
    logic         new_word;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_valid;
    fetch_entry_t skid_q;
    fetch_entry_t new_entry;

    // Fetch-side qualifiers shared by the FSM outputs and the datapath.
    always_comb begin
        aligned    = pc_aligned(pc);
        // A word may be taken when the skid has room or is draining this cycle.
        fetch_ok   = !skid_valid || !id_stall;
        accept     = (state == IF_RUN) && ibus_req && ibus_ack;
        adel_issue = (state == IF_RUN) && started && fetch_ok && !aligned && !adel_done;
        new_word   = (accept || adel_issue) && !redirect_en;
        new_entry  = aligned ? '{inst: ibus_rdata, pc: pc, adel: 1'b0}
                             : '{inst: NOP_CODE_P, pc: pc, adel: 1'b1};
        skid_drain = skid_valid && !id_stall;
        // Park the new word if IF/ID is occupied and stalled, or is being refilled from the skid.
        skid_load  = new_word && (id_stall ? id_valid : skid_valid);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IF_RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // FSM next state: enter DROP when a redirect abandons an unacknowledged request.
    always_comb begin
        // NOTE: assigning a default first keeps this block free of inferred latches.
        state_nxt = state;
        case (state)
            IF_RUN:  if (redirect_en && ibus_req && !ibus_ack) state_nxt = IF_DROP;
            IF_DROP: if (ibus_ack) state_nxt = IF_RUN;
            default: state_nxt = IF_RUN;
        endcase
    end

    // FSM outputs: bus request and address; DROP keeps the stale request up until acked.
    always_comb begin
        ibus_req  = 1'b0;
        ibus_addr = {pc[PC_W-1:2], 2'b00};
        case (state)
            IF_RUN:  ibus_req = started && fetch_ok && aligned;
            IF_DROP: begin
                ibus_req  = 1'b1;
                ibus_addr = drop_addr;
            end
            default: ibus_req = 1'b0;
        endcase
    end

    // PC, stale-address capture and misalignment bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC_P;
            drop_addr <= '0;
            started   <= 1'b0;
            adel_done <= 1'b0;
        end else begin
            started <= 1'b1;
            if (state == IF_RUN && state_nxt == IF_DROP) begin
                drop_addr <= ibus_addr;
            end
            if (redirect_en) begin
                pc        <= redirect_pc;
                adel_done <= 1'b0;
            end else if (new_word) begin
                if (aligned) begin
                    pc <= pc + 32'd4;
                end else begin
                    adel_done <= 1'b1;
                end
            end
        end
    end

    // IF/ID latch: redirect flush, skid refill, direct load, bubble, or hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_inst_code <= NOP_CODE_P;
            id_pc        <= '0;
            id_valid     <= 1'b0;
            id_exc_adel  <= 1'b0;
        end else if (redirect_en) begin
            id_inst_code <= NOP_CODE_P;
            id_valid     <= 1'b0;
            id_exc_adel  <= 1'b0;
        end else if (skid_drain) begin
            id_inst_code <= skid_q.inst;
            id_pc        <= skid_q.pc;
            id_exc_adel  <= skid_q.adel;
            id_valid     <= 1'b1;
        end else if (new_word && !skid_load) begin
            id_inst_code <= new_entry.inst;
            id_pc        <= new_entry.pc;
            id_exc_adel  <= new_entry.adel;
            id_valid     <= 1'b1;
        end else if (!id_stall) begin
            id_inst_code <= NOP_CODE_P;
            id_valid     <= 1'b0;
            id_exc_adel  <= 1'b0;
        end
    end

    if_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_en),
        .load  (skid_load),
        .drain (skid_drain),
        .d     (new_entry),
        .valid (skid_valid),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by a randomized run
// checked against a stream-level model of the instruction sequence seen by ID.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic        id_stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] id_inst_code;
    logic [31:0] id_pc;
    logic        id_valid;
    logic        id_exc_adel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ibus_req     (ibus_req),
        .ibus_addr    (ibus_addr),
        .ibus_ack     (ibus_ack),
        .ibus_rdata   (ibus_rdata),
        .id_stall     (id_stall),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .id_inst_code (id_inst_code),
        .id_pc        (id_pc),
        .id_valid     (id_valid),
        .id_exc_adel  (id_exc_adel)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs for the coming edge; the bus responder returns memory data for the current address.
    task automatic drive(input logic stall, input logic ack, input logic redir, input logic [31:0] rpc);
        id_stall    = stall;
        ibus_ack    = ack;
        redirect_en = redir;
        redirect_pc = rpc;
        #1;
        ibus_rdata = mem_word(ibus_addr);
        #1;
    endtask

    logic [31:0] p;
    logic [31:0] exp_pc;
    logic        dead;
    logic        prev_hold;
    logic [31:0] prev_addr;
    int          consumed;
    logic        st, ak, rd;
    logic [31:0] rp;

    initial begin
        // Reset values
        #12;
        check("rst_req", ibus_req, 0);
        check("rst_valid", id_valid, 0);
        check("rst_adel", id_exc_adel, 0);
        check("rst_inst", id_inst_code, NOP);
        check("rst_pc", id_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Ack every cycle: addresses step by 4, ID trails by one edge
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            check("t1_addr", ibus_addr, RST_PC + 32'(4 * i));
            check("t1_req", ibus_req, 1);
            if (i > 0) begin
                check("t1_id_pc", id_pc, RST_PC + 32'(4 * (i - 1)));
                check("t1_id_inst", id_inst_code, mem_word(RST_PC + 32'(4 * (i - 1))));
                check("t1_id_valid", id_valid, 1);
            end else begin
                check("t1_first_invalid", id_valid, 0);
            end
            tick();
        end

        // Three wait states: address stable for four cycles, one valid pulse
        for (int i = 0; i < 4; i++) begin
            drive(0, (i == 3), 0, 0);
            check("t2_addr_hold", ibus_addr, 32'hBFC0_000C);
            check("t2_req_hold", ibus_req, 1);
            if (i > 0) check("t2_no_valid", id_valid, 0);
            tick();
        end
        check("t2_valid", id_valid, 1);
        check("t2_id_pc", id_pc, 32'hBFC0_000C);
        check("t2_inst", id_inst_code, mem_word(32'hBFC0_000C));
        drive(0, 0, 0, 0);
        tick();
        check("t2_pulse_end", id_valid, 0);

        // Stall with acks pending: A held, B parked, req low; release gives B then C
        p = 32'hBFC0_0010;
        drive(0, 1, 0, 0);
        tick();
        drive(1, 1, 0, 0);
        check("t3_req_b", ibus_req, 1);
        check("t3_addr_b", ibus_addr, p + 4);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 0);
            check("t3_req_low", ibus_req, 0);
            check("t3_hold_pc", id_pc, p);
            check("t3_hold_inst", id_inst_code, mem_word(p));
            check("t3_hold_valid", id_valid, 1);
            tick();
        end
        drive(0, 1, 0, 0);
        check("t3_req_resume", ibus_req, 1);
        check("t3_addr_c", ibus_addr, p + 8);
        tick();
        check("t3_b_pc", id_pc, p + 4);
        check("t3_b_inst", id_inst_code, mem_word(p + 4));
        drive(0, 0, 0, 0);
        check("t3_addr_d", ibus_addr, p + 12);
        tick();
        check("t3_c_pc", id_pc, p + 8);
        check("t3_c_inst", id_inst_code, mem_word(p + 8));
        drive(0, 1, 0, 0);
        tick();
        check("t3_d_pc", id_pc, p + 12);
        check("t3_d_valid", id_valid, 1);

        // Redirect with a request outstanding, ack two cycles later
        drive(0, 0, 1, 32'h8000_0180);
        check("t4_req_pending", ibus_req, 1);
        tick();
        check("t4_flush_valid", id_valid, 0);
        check("t4_flush_inst", id_inst_code, NOP);
        drive(0, 0, 0, 0);
        check("t4_stale_req", ibus_req, 1);
        check("t4_stale_addr", ibus_addr, 32'hBFC0_0020);
        tick();
        drive(0, 1, 0, 0);
        check("t4_stale_addr2", ibus_addr, 32'hBFC0_0020);
        tick();
        check("t4_dropped", id_valid, 0);
        drive(0, 0, 0, 0);
        check("t4_new_addr", ibus_addr, 32'h8000_0180);
        check("t4_new_req", ibus_req, 1);
        tick();
        drive(0, 1, 0, 0);
        check("t4_still_invalid", id_valid, 0);
        tick();
        check("t4_valid", id_valid, 1);
        check("t4_pc", id_pc, 32'h8000_0180);
        check("t4_inst", id_inst_code, mem_word(32'h8000_0180));

        // Redirect and ack in the same cycle
        drive(0, 1, 1, 32'h8000_1000);
        tick();
        check("t5_valid", id_valid, 0);
        check("t5_inst", id_inst_code, NOP);
        check("t5_addr", ibus_addr, 32'h8000_1000);
        check("t5_req", ibus_req, 1);
        drive(0, 1, 0, 0);
        tick();
        check("t5_pc", id_pc, 32'h8000_1000);
        check("t5_got", id_inst_code, mem_word(32'h8000_1000));

        // Misaligned redirect target
        drive(0, 1, 1, 32'h8000_0002);
        tick();
        drive(0, 0, 0, 0);
        check("t6_no_req", ibus_req, 0);
        tick();
        check("t6_valid", id_valid, 1);
        check("t6_adel", id_exc_adel, 1);
        check("t6_inst", id_inst_code, NOP);
        check("t6_pc", id_pc, 32'h8000_0002);
        drive(0, 0, 0, 0);
        check("t6_no_req2", ibus_req, 0);
        tick();
        check("t6_once_valid", id_valid, 0);
        check("t6_once_adel", id_exc_adel, 0);
        drive(0, 0, 0, 0);
        tick();
        check("t6_no_repeat", id_valid, 0);
        drive(0, 0, 1, 32'hBFC0_0100);
        tick();

        // Reset in the middle of a wait
        drive(0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_req", ibus_req, 0);
        check("t7_valid", id_valid, 0);
        check("t7_inst", id_inst_code, NOP);
        check("t7_pc", id_pc, 0);
        check("t7_adel", id_exc_adel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drive(0, 0, 0, 0);
        check("t7_refetch_addr", ibus_addr, RST_PC);
        check("t7_refetch_req", ibus_req, 1);

        // Randomized run against the stream model: ID must see consecutive words of the
        // current stream, one AdEL marker for a misaligned stream, and nothing stale.
        exp_pc    = RST_PC;
        dead      = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
        consumed  = 0;
        for (int c = 0; c < 3000; c++) begin
            st = ($urandom_range(0, 3) == 0);
            ak = ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 39) == 0);
            rp = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rp[1:0] = 2'b10;
            drive(st, ak, rd, rp);
            if (prev_hold) begin
                check("bus_req_held", ibus_req, 1);
                check("bus_addr_held", ibus_addr, prev_addr);
            end
            if (ibus_req) check("bus_addr_aligned", ibus_addr & 32'h3, 0);
            if (!id_valid) check("bubble_nop", id_inst_code, NOP);
            if (id_valid && !st) begin
                if (dead) begin
                    check("no_issue_after_adel", id_valid, 0);
                end else if (exp_pc[1:0] != 2'b00) begin
                    check("rnd_adel_flag", id_exc_adel, 1);
                    check("rnd_adel_inst", id_inst_code, NOP);
                    check("rnd_adel_pc", id_pc, exp_pc);
                    dead = 1'b1;
                end else begin
                    check("rnd_pc", id_pc, exp_pc);
                    check("rnd_inst", id_inst_code, mem_word(exp_pc));
                    check("rnd_adel_clear", id_exc_adel, 0);
                    exp_pc = exp_pc + 32'd4;
                end
                consumed++;
            end
            if (rd) begin
                exp_pc = rp;
                dead   = 1'b0;
            end
            prev_hold = ibus_req && !ak;
            prev_addr = ibus_addr;
            tick();
        end
        check("rnd_progress", 32'(consumed > 300), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
